// File: rtl/if_id_skid_pkg.sv
// ============================================================================
// Module : if_id_skid_pkg
// Brief  : Shared constants and state encodings for the IF/ID skid stage.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_id_skid_pkg;

  localparam logic [31:0] ZeroWord       = 32'h0000_0000;
  localparam int          DEFAULT_HIST_W = 12;

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    IFID_EMPTY = 2'd0,
    IFID_ONE   = 2'd1,
    IFID_FULL  = 2'd2
  } ifid_state_e;

endpackage

`default_nettype wire

// File: rtl/if_id_skid_sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Up-counter that sticks at all-ones instead of wrapping.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/if_id_skid.sv
// ============================================================================
// Module : if_id_skid
// Brief  : IF/ID pipeline register with valid/ready handshake, 2-entry skid
//          buffer, mispredict flush and stall/bubble performance counters.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_skid
  import if_id_skid_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int HIST_W = DEFAULT_HIST_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [INST_W-1:0] in_inst,
  input  logic              in_pdt_res,
  input  logic              in_which_pdt,
  input  logic [HIST_W-1:0] in_history,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic              out_pdt_res,
  output logic              out_which_pdt,
  output logic [HIST_W-1:0] out_history,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int PAY_W = ADDR_W + INST_W + 2 + HIST_W;

  ifid_state_e      r_state;
  ifid_state_e      w_next_state;
  logic [PAY_W-1:0] r_head;
  logic [PAY_W-1:0] r_skid;
  logic             r_in_ready;
  logic             r_seen;

  logic [PAY_W-1:0] w_in_pay;
  logic [PAY_W-1:0] w_out_pay;
  logic             w_accept;
  logic             w_pop;
  logic             w_out_valid;
  logic             w_load_head_in;
  logic             w_load_skid;
  logic             w_head_from_skid;
  logic             w_clear;

  assign w_in_pay    = {in_pc, in_inst, in_pdt_res, in_which_pdt, in_history};
  assign w_out_valid = (r_state != IFID_EMPTY);
  assign w_accept    = in_valid & r_in_ready & ~flush;
  assign w_pop       = w_out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IFID_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state != IFID_FULL);
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_load_head_in   = 1'b0;
    w_load_skid      = 1'b0;
    w_head_from_skid = 1'b0;
    w_clear          = 1'b0;
    if (flush) begin
      w_next_state = IFID_EMPTY;
      w_clear      = 1'b1;
    end else begin
      case (r_state)
        IFID_EMPTY: begin
          if (w_accept) begin
            w_next_state   = IFID_ONE;
            w_load_head_in = 1'b1;
          end
        end
        IFID_ONE: begin
          if (w_accept && !w_pop) begin
            w_next_state = IFID_FULL;
            w_load_skid  = 1'b1;
          end else if (w_accept && w_pop) begin
            w_load_head_in = 1'b1;
          end else if (w_pop) begin
            w_next_state = IFID_EMPTY;
            w_clear      = 1'b1;
          end
        end
        IFID_FULL: begin
          if (w_pop) begin
            w_next_state     = IFID_ONE;
            w_head_from_skid = 1'b1;
          end
        end
        default: begin
          w_next_state = IFID_EMPTY;
          w_clear      = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head <= '0;
      r_skid <= '0;
      r_seen <= 1'b0;
    end else begin
      if (w_clear) begin
        r_head <= '0;
      end else if (w_load_head_in) begin
        r_head <= w_in_pay;
      end else if (w_head_from_skid) begin
        r_head <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_in_pay;
      end else if (w_clear || w_head_from_skid) begin
        r_skid <= '0;
      end
      if (w_accept) begin
        r_seen <= 1'b1;
      end
    end
  end

  // Bubbles present a zero payload so decode sees a NOP.
  assign w_out_pay = w_out_valid ? r_head : '0;

  assign out_valid     = w_out_valid;
  assign in_ready      = r_in_ready;
  assign occupancy     = r_state;
  assign out_pc        = w_out_valid ? w_out_pay[PAY_W-1 -: ADDR_W] : ADDR_W'(ZeroWord);
  assign out_inst      = w_out_valid ? w_out_pay[HIST_W+2 +: INST_W] : INST_W'(ZeroWord);
  assign out_pdt_res   = w_out_pay[HIST_W+1];
  assign out_which_pdt = w_out_pay[HIST_W];
  assign out_history   = w_out_pay[HIST_W-1:0];

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (w_out_valid & ~out_ready),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .en  (r_seen & ~w_out_valid),
    .cnt (bubble_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_if_id_skid.sv
// ============================================================================
// Module : tb_if_id_skid
// Brief  : Directed table-driven bench for if_id_skid (CNT_W=4 for saturation).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_id_skid;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        in_pdt_res;
  logic        in_which_pdt;
  logic [11:0] in_history;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_pdt_res;
  logic        out_which_pdt;
  logic [11:0] out_history;
  logic [1:0]  occupancy;
  logic [3:0]  stall_cnt;
  logic [3:0]  bubble_cnt;

  int n_vec = 0;
  int n_err = 0;

  if_id_skid #(.ADDR_W(32), .INST_W(32), .HIST_W(12), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_inst      (in_inst),
    .in_pdt_res   (in_pdt_res),
    .in_which_pdt (in_which_pdt),
    .in_history   (in_history),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .out_pdt_res  (out_pdt_res),
    .out_which_pdt(out_which_pdt),
    .out_history  (out_history),
    .occupancy    (occupancy),
    .stall_cnt    (stall_cnt),
    .bubble_cnt   (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        f;
    logic        iv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [13:0] meta;   // {pdt_res, which_pdt, history}
    logic        ordy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    logic [13:0] emeta;
    logic [1:0]  eocc;
    logic        erdy;
    logic        cs;
    logic [3:0]  est;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic f, input logic iv, input logic [31:0] pc,
                     input logic [31:0] inst, input logic [13:0] meta,
                     input logic ordy, input logic ev, input logic [31:0] epc,
                     input logic [31:0] einst, input logic [13:0] emeta,
                     input logic [1:0] eocc, input logic erdy,
                     input logic cs, input logic [3:0] est);
    vec_t v;
    v.f = f; v.iv = iv; v.pc = pc; v.inst = inst; v.meta = meta; v.ordy = ordy;
    v.ev = ev; v.epc = epc; v.einst = einst; v.emeta = emeta;
    v.eocc = eocc; v.erdy = erdy; v.cs = cs; v.est = est;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic iv, input logic [31:0] pc,
                       input logic [31:0] inst, input logic [13:0] meta,
                       input logic ordy);
    flush        = f;
    in_valid     = iv;
    in_pc        = pc;
    in_inst      = inst;
    in_pdt_res   = meta[13];
    in_which_pdt = meta[12];
    in_history   = meta[11:0];
    out_ready    = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b1, 32'h50, 32'h13, 14'h3FFF, 1'b0);

    // Reset held with in_valid asserted.
    repeat (3) step();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd0);
    check("rst_occ",       {62'd0, occupancy}, 64'd0);
    check("rst_out_pc",    {32'd0, out_pc},    64'd0);
    check("rst_stall",     {60'd0, stall_cnt}, 64'd0);
    check("rst_bubble",    {60'd0, bubble_cnt}, 64'd0);
    rst = 1'b1;
    #1;
    check("rel_in_ready_pre", {63'd0, in_ready}, 64'd0);
    step();
    check("rel_in_ready_post", {63'd0, in_ready}, 64'd1);
    check("rel_no_accept_occ", {62'd0, occupancy}, 64'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 14'h0, 1'b0);
    repeat (2) step();
    check("idle_bubble_pre_accept", {60'd0, bubble_cnt}, 64'd0);

    // Streaming at full throughput.
    add(0,1,32'h100,32'h00000113,14'h0001,1, 1,32'h100,32'h00000113,14'h0001,2'd1,1, 0,4'd0);
    add(0,1,32'h104,32'h00100193,14'h2002,1, 1,32'h104,32'h00100193,14'h2002,2'd1,1, 0,4'd0);
    add(0,1,32'h108,32'h00200213,14'h1004,1, 1,32'h108,32'h00200213,14'h1004,2'd1,1, 0,4'd0);
    add(0,1,32'h10C,32'h00300293,14'h3ABC,1, 1,32'h10C,32'h00300293,14'h3ABC,2'd1,1, 0,4'd0);
    add(0,1,32'h110,32'h00400313,14'h0FFF,1, 1,32'h110,32'h00400313,14'h0FFF,2'd1,1, 0,4'd0);
    add(0,1,32'h114,32'h00500393,14'h3800,1, 1,32'h114,32'h00500393,14'h3800,2'd1,1, 0,4'd0);
    add(0,1,32'h118,32'h00600413,14'h0555,1, 1,32'h118,32'h00600413,14'h0555,2'd1,1, 0,4'd0);
    add(0,1,32'h11C,32'h00700493,14'h20AA,1, 1,32'h11C,32'h00700493,14'h20AA,2'd1,1, 0,4'd0);
    add(0,0,32'h0,  32'h0,       14'h0,   1, 0,32'h0,  32'h0,       14'h0,   2'd0,1, 1,4'd0);
    // Backpressure into the skid entry.
    add(0,1,32'h200,32'hAAAA0001,14'h0123,0, 1,32'h200,32'hAAAA0001,14'h0123,2'd1,1, 0,4'd0);
    add(0,1,32'h204,32'hAAAA0002,14'h3ABC,0, 1,32'h200,32'hAAAA0001,14'h0123,2'd2,0, 1,4'd1);
    add(0,1,32'h208,32'hAAAA0003,14'h0000,0, 1,32'h200,32'hAAAA0001,14'h0123,2'd2,0, 0,4'd0);
    add(0,0,32'h0,  32'h0,       14'h0,   0, 1,32'h200,32'hAAAA0001,14'h0123,2'd2,0, 1,4'd3);
    add(0,0,32'h0,  32'h0,       14'h0,   1, 1,32'h204,32'hAAAA0002,14'h3ABC,2'd1,1, 1,4'd3);
    add(0,0,32'h0,  32'h0,       14'h0,   1, 0,32'h0,  32'h0,       14'h0,   2'd0,1, 0,4'd0);
    // Flush from FULL, from EMPTY, and from ONE with pop+accept.
    add(0,1,32'h240,32'hBBBB0001,14'h0111,0, 1,32'h240,32'hBBBB0001,14'h0111,2'd1,1, 0,4'd0);
    add(0,1,32'h244,32'hBBBB0002,14'h2222,0, 1,32'h240,32'hBBBB0001,14'h0111,2'd2,0, 1,4'd4);
    add(1,1,32'h300,32'hDEAD0300,14'h3FFF,0, 0,32'h0,  32'h0,       14'h0,   2'd0,1, 1,4'd5);
    add(0,0,32'h0,  32'h0,       14'h0,   1, 0,32'h0,  32'h0,       14'h0,   2'd0,1, 0,4'd0);
    add(1,1,32'h304,32'hDEAD0304,14'h3FFF,1, 0,32'h0,  32'h0,       14'h0,   2'd0,1, 0,4'd0);
    add(0,1,32'h308,32'hCCCC0308,14'h1333,1, 1,32'h308,32'hCCCC0308,14'h1333,2'd1,1, 0,4'd0);
    add(1,1,32'h30C,32'hDEAD030C,14'h3FFF,1, 0,32'h0,  32'h0,       14'h0,   2'd0,1, 0,4'd0);
    add(0,0,32'h0,  32'h0,       14'h0,   1, 0,32'h0,  32'h0,       14'h0,   2'd0,1, 1,4'd5);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].f, vq[i].iv, vq[i].pc, vq[i].inst, vq[i].meta, vq[i].ordy);
      step();
      check($sformatf("v%0d_valid", i), {63'd0, out_valid}, {63'd0, vq[i].ev});
      check($sformatf("v%0d_pc", i),    {32'd0, out_pc},    {32'd0, vq[i].epc});
      check($sformatf("v%0d_inst", i),  {32'd0, out_inst},  {32'd0, vq[i].einst});
      check($sformatf("v%0d_meta", i),
            {50'd0, out_pdt_res, out_which_pdt, out_history}, {50'd0, vq[i].emeta});
      check($sformatf("v%0d_occ", i),   {62'd0, occupancy}, {62'd0, vq[i].eocc});
      check($sformatf("v%0d_rdy", i),   {63'd0, in_ready},  {63'd0, vq[i].erdy});
      if (vq[i].cs)
        check($sformatf("v%0d_stall", i), {60'd0, stall_cnt}, {60'd0, vq[i].est});
    end

    // Asynchronous reset while an entry is held.
    drive(1'b0, 1'b1, 32'h400, 32'h44440400, 14'h0ABC, 1'b0);
    step();
    check("mid_pre_valid", {63'd0, out_valid}, 64'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_pc",    {32'd0, out_pc},    64'd0);
    check("mid_rst_inst",  {32'd0, out_inst},  64'd0);
    check("mid_rst_occ",   {62'd0, occupancy}, 64'd0);
    check("mid_rst_rdy",   {63'd0, in_ready},  64'd0);
    check("mid_rst_stall", {60'd0, stall_cnt}, 64'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 14'h0, 1'b0);
    #3;
    rst = 1'b1;
    step();
    check("mid_rel_rdy", {63'd0, in_ready}, 64'd1);
    repeat (3) step();
    check("mid_bubble_idle", {60'd0, bubble_cnt}, 64'd0);

    // Bubble counting starts after the first accept.
    drive(1'b0, 1'b1, 32'h500, 32'h55550500, 14'h0, 1'b1);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 14'h0, 1'b1);
    step();
    check("bub_after_pop", {60'd0, bubble_cnt}, 64'd0);
    repeat (3) step();
    check("bub_three", {60'd0, bubble_cnt}, 64'd3);

    // Stall counter saturation at 4 bits.
    drive(1'b0, 1'b1, 32'h600, 32'h66660600, 14'h0, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 14'h0, 1'b0);
    repeat (20) step();
    check("sat_stall", {60'd0, stall_cnt}, 64'd15);
    check("sat_bubble_hold", {60'd0, bubble_cnt}, 64'd4);
    check("sat_head_pc", {32'd0, out_pc}, 64'h600);
    check("sat_occ", {62'd0, occupancy}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
